// File: rtl/rv_fifo.sv
// Parametrised valid/ready FIFO with flush, occupancy status and a sticky
// overflow protocol flag. Pointers carry an extra wrap bit for full/empty.
module rv_fifo #(
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          ovf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("rv_fifo: DEPTH must be a power of two and >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
    $error("rv_fifo: AF_THRESH must lie in 1..DEPTH");
  end

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  // Handshake: a transfer happens on an edge where valid && ready are both
  // high; in_ready depends only on registered state and flush, never on
  // out_ready, and out_valid depends only on registered state.
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign in_ready    = !full && !flush;
  assign out_valid   = !empty;
  assign out_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_THRESH));
  assign ovf_err     = ovf_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (in_valid && full && !flush);
    if (flush) begin
      // Flush beats any concurrent push/pop; array contents are left as-is.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end
endmodule

// File: tb/tb_rv_fifo.sv
// Self-checking bench for rv_fifo: directed scenarios plus random traffic,
// all compared each cycle against a queue-based model of the FIFO.
module tb_rv_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, full, empty, almost_full, ovf_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];
  bit            exp_ovf = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rv_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .ovf_err(ovf_err)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [DW-1:0] act,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs to the model mid-cycle, then advance
  // the model with the inputs held across the rising edge.
  task automatic step();
    int  sz;
    bit  do_push, do_pop;
    @(negedge clk);
    sz = exp_q.size();
    check_eq("count",       DW'(count),       DW'(sz));
    check_eq("empty",       DW'(empty),       DW'(sz == 0));
    check_eq("full",        DW'(full),        DW'(sz == DEPTH));
    check_eq("almost_full", DW'(almost_full), DW'(sz >= DEPTH - 1));
    check_eq("out_valid",   DW'(out_valid),   DW'(sz != 0));
    check_eq("in_ready",    DW'(in_ready),    DW'((sz < DEPTH) && !flush));
    check_eq("ovf_err",     DW'(ovf_err),     DW'(exp_ovf));
    if (sz != 0) check_eq("out_data", out_data, exp_q[0]);
    do_push = in_valid && (sz < DEPTH) && !flush;
    do_pop  = out_ready && (sz != 0) && !flush;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (in_valid && sz == DEPTH && !flush) exp_ovf = 1'b1;
      if (flush) exp_q.delete();
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(in_data);
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r,
                       input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;

    // Reset state
    check_eq("rst_count", DW'(count), 0);
    check_eq("rst_empty", DW'(empty), 1);
    check_eq("rst_full", DW'(full), 0);
    check_eq("rst_af", DW'(almost_full), 0);
    check_eq("rst_out_valid", DW'(out_valid), 0);
    check_eq("rst_in_ready", DW'(in_ready), 1);
    check_eq("rst_ovf", DW'(ovf_err), 0);
    step();

    // Fill with A0..A3, consumer stalled
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
      step();
      if (i == 2) check_eq("fill_af3", DW'(almost_full), 1);
    end
    idle();
    check_eq("fill_full", DW'(full), 1);
    check_eq("fill_in_ready", DW'(in_ready), 0);
    check_eq("fill_count", DW'(count), DEPTH);
    step();

    // Drain
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check_eq("drain_data", out_data, DW'(32'hA0 + i));
      step();
    end
    check_eq("drain_empty", DW'(empty), 1);
    check_eq("drain_out_valid", DW'(out_valid), 0);

    // Preload two entries, then stream 0..63 across many pointer wraps
    drive(1'b1, 32'hF0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hF1, 1'b0, 1'b0); step();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      step();
      check_eq("stream_count", DW'(count), 2);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) step();
    check_eq("stream_empty", DW'(empty), 1);

    // Flush together with a push of 0x55
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(32'h10 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h55, 1'b0, 1'b1);
    step();
    check_eq("flush_count", DW'(count), 0);
    check_eq("flush_empty", DW'(empty), 1);
    drive(1'b1, 32'h66, 1'b0, 1'b0);
    step();
    idle();
    check_eq("flush_first_out", out_data, 32'h66);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

    // Random back-pressure, well-behaved producer, occasional flush
    for (int c = 0; c < 10000; c++) begin
      drive((exp_q.size() < DEPTH) && ($urandom_range(0, 3) != 0),
            DW'($urandom), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 99) == 0));
      step();
    end
    check_eq("rand_ovf", DW'(ovf_err), 0);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (DEPTH + 1) step();

    // Overflow flag: sticky through flush, cleared by reset
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'hCC, 1'b0, 1'b0);
    step();
    check_eq("ovf_set", DW'(ovf_err), 1);
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    check_eq("ovf_after_flush", DW'(ovf_err), 1);
    check_eq("ovf_flush_count", DW'(count), 0);
    idle();
    drive(1'b1, 32'hD0, 1'b0, 1'b0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("ovf_after_rst", DW'(ovf_err), 0);
    check_eq("rst_mid_count", DW'(count), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rv_fifo.md
# rv_fifo

Parametrised valid/ready FIFO that decouples a producer and a consumer following the core's `rv_if` handshake convention. It is the generalised successor to the single-register pipeline stage: it has configurable data width, depth and almost-full threshold, a synchronous flush, and occupancy status. It sits between core-side request paths (for example IMEM/DMEM and MMIO request/response) wherever one stage of back-pressure slack is not enough.

## Interface
Parameters:
- `DW`, 32: data width in bits.
- `DEPTH`, 4: number of entries. Must be a power of two and ≥ 2; elaborate-time `$error` otherwise.
- `AF_THRESH`, DEPTH-1: `almost_full` asserts when count ≥ AF_THRESH. Legal range is 1..DEPTH.
- `CW`, $clog2(DEPTH+1): width of the count output. Derived; do not override.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: synchronous clear of all contents.
- `in_valid`, in, 1: producer has data.
- `in_ready`, out, 1: FIFO accepts data.
- `in_data`, in, DW: write data.
- `out_valid`, out, 1: head entry is valid.
- `out_ready`, in, 1: consumer takes the head.
- `out_data`, out, DW: head entry.
- `count`, out, CW: current occupancy, 0..DEPTH.
- `full`, out, 1: count == DEPTH.
- `empty`, out, 1: count == 0.
- `almost_full`, out, 1: count ≥ AF_THRESH.
- `ovf_err`, out, 1: sticky; set when `in_valid` is high while `full` is high and `flush` is low. Cleared only by `rst`.

## Operation
- Storage is a DEPTH×DW register array with read and write pointers of width $clog2(DEPTH)+1. The extra MSB is the wrap bit.
  - full: pointers are equal except for opposite MSBs.
  - empty: pointers are fully equal.
- The `count` register is updated in step with the pointers:
  - push only: +1.
  - pop only: −1.
  - both, or neither: unchanged.
- push = `in_valid & in_ready`.
- pop = `out_valid & out_ready`.
- `in_ready` = `!full & !flush`. There is no combinational path from `out_ready` to `in_ready`. When the FIFO is full, a push in the same cycle as a pop is refused.
- `out_valid` = `!empty`. It is a function of registered state only.
- `out_data` = `mem[rd_ptr]`. It is held stable while `out_valid & !out_ready`.
- Pointers wrap modulo 2·DEPTH, so array indexing wraps modulo DEPTH with no special case.
- Flush has priority over push and pop in the same cycle.
  - Both pointers and `count` go to 0.
  - A concurrent push is dropped. The producer sees `in_ready`=0, so no handshake is lost.
  - Array contents are not cleared.
- `ovf_err` is a protocol checker only. A producer holding valid against a full FIFO is legal back-pressure, but this block's users must not rely on it. The flag is a debug aid and does not alter data.

## Timing
- Reset values:
  - `count`=0, `empty`=1, `full`=0, `almost_full`=0 (if AF_THRESH ≥ 1).
  - `out_valid`=0, `in_ready`=1, `ovf_err`=0.
  - `out_data` is undefined; the array is not reset.
- Reset mid-operation discards all contents at the next edge, identical to flush. It also clears `ovf_err`.
- Latency: a push at edge N makes `out_valid`=1 after edge N, i.e. visible in the cycle following acceptance. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- When empty, a push and `out_ready` in the same cycle produce no pop. After the edge, count=1.
- When full, `out_ready`=1 pops one entry. `in_ready` rises in the next cycle.
- Status outputs (`full`, `empty`, `almost_full`, `count`) are derived from registered state and reflect the post-edge occupancy.

## Test plan
- **Reset, then fill.** Apply `rst`, then push 0xA0..0xA3 with DEPTH=4 and `out_ready`=0 → `almost_full`=1 after the 3rd push, `full`=1 and `in_ready`=0 after the 4th, `count`=4.
- **Drain.** From full, hold `out_ready`=1 → `out_data` reads 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, then `empty`=1 and `out_valid`=0.
- **Streaming with wrap.** Continuous push and pop of 0..63, starting from count=2 → `count` stays 2, output order is preserved across pointer wraps, and no bubbles appear.
- **Random back-pressure.** Random `in_valid`/`out_ready` over 10k cycles, checked against a scoreboard queue → exact in-order match, `count` always equals scoreboard size, `ovf_err`=0 if the producer is well-behaved.
- **Flush with push.** At count=3, assert `flush` together with `in_valid` carrying 0x55 → next cycle `count`=0, `empty`=1; 0x55 is never output. A subsequent push of 0x66 is the first value output.
- **Overflow flag and reset.** With the FIFO full, hold `in_valid`=1 → `ovf_err`=1 next cycle, persists through a flush, and clears only after `rst`.
